pint_arb: RTL and testbench
===========================

Name: pint_arb

Overview:
- Two-requester frame arbiter and sequencer in front of the PINT serial interface block (`pint_int`).
- Accepts byte-stream frames from two on-chip masters, for example the host command path and the debug/DMA path.
- Round-robins between them, loads each frame's bytes into the PINT TX FIFO, then fires the transmit request and waits for completion.
- Forwards the PINT receive stream to a shared RX output.

Parameters:
- MAX_BYTES, 64: maximum payload bytes per frame. Must be less than or equal to the PINT TX FIFO free depth.
- START_TO, 16: cycles allowed after `pint_tx_req` for `pint_busy` to rise.
- CW, 8: width of the byte counter and the timeout counter. Must satisfy 2^CW > max(MAX_BYTES, START_TO).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- r0_valid  in  1  requester 0 byte valid
- r0_data  in  8  requester 0 byte
- r0_last  in  1  this byte ends the frame
- r0_cmd  in  1  frame command type, sampled with the first byte
- r0_ready  out  1  requester 0 byte accepted this cycle when valid is also high
- r0_done  out  1  one-cycle pulse when requester 0's frame finishes (success or error)
- r1_valid, r1_data, r1_last, r1_cmd, r1_ready, r1_done: same as requester 0, for requester 1
- pint_busy  in  1  PINT TX or RX in progress
- pint_tx_char  out  8  byte pushed into the PINT FIFO
- pint_tx_char_latch  out  1  FIFO push strobe
- pint_tx_req  out  1  start-transmit pulse
- pint_tx_cmd_type  out  1  command type for the frame
- pint_rx_latch  in  1  received byte strobe
- pint_rx_req  in  1  receive frame end
- pint_rx_data  in  8  received byte
- rx_valid  out  1  registered copy of pint_rx_latch
- rx_byte  out  8  byte captured on pint_rx_latch
- rx_end  out  1  registered copy of pint_rx_req
- grant  out  2  one-hot current owner; 00 when idle
- err_start_to  out  1  sticky: PINT never went busy after a kick
- err_overflow  out  1  sticky: frame truncated at MAX_BYTES
- err_clr  in  1  synchronous clear of both sticky errors

Behaviour:
- Reset: state IDLE; all outputs 0; rr_last=1, so r0 wins the first tie; counters 0; errors cleared.
  - Reset mid-frame abandons the frame without a done pulse. PINT shares the reset, so its FIFO is flushed as well.
- States: IDLE, LOAD, WAIT_IDLE, KICK, WAIT_START, WAIT_DONE.
- IDLE:
  - If any rN_valid is high, register grant next cycle and enter LOAD.
  - If both are valid, grant the one not equal to rr_last, then set rr_last to the winner.
  - One idle cycle between frames is mandatory.
- LOAD:
  - rN_ready = (state==LOAD) & grant[N], combinational.
  - On valid&ready: pint_tx_char <= data and pint_tx_char_latch <= 1, so the latch strobe follows the handshake by one cycle. Increment the byte count.
  - Capture rN_cmd on the first byte into cmd_q.
  - If last=1, or the count reaches MAX_BYTES, go to WAIT_IDLE.
  - If the count reached MAX_BYTES without last, set err_overflow. The requester's remaining bytes are then accepted and discarded in IDLE-drain: ready stays high until its last byte, with no FIFO push.
- WAIT_IDLE: when pint_busy==0, go to KICK. The earliest KICK is 2 cycles after the last accepted byte, so it is always after the final tx_char_latch.
- KICK:
  - pint_tx_req=1 for exactly one cycle.
  - pint_tx_cmd_type=cmd_q, held from KICK until done.
  - Go to WAIT_START with the timer cleared.
- WAIT_START:
  - If pint_busy==1, go to WAIT_DONE.
  - Otherwise, when the timer reaches START_TO-1, set err_start_to, pulse rN_done, and go to IDLE.
- WAIT_DONE: when pint_busy==0, pulse rN_done for 1 cycle, clear grant, and go to IDLE.
- pint_tx_req is never asserted while pint_busy=1. A busy rising in WAIT_START from an RX frame is accepted as the start; WAIT_DONE then waits out RX and the TX that follows.
- RX path: independent of the state machine, 1-cycle registered passthrough.
  - rx_byte updates only on pint_rx_latch.
  - rx_valid and rx_end are single-cycle pulses.
  - A simultaneous rx_latch and rx_req are both forwarded in the same cycle.
- Errors: sticky until err_clr. An err_clr coincident with a new error event results in the error staying set.
- Counters saturate; no wrap.

Test Plan:
- r0 sends 3 bytes 0xA1,0xA2,0xA3 (last on the 3rd), cmd=1, with pint_busy low -> tx_char_latch pulses 3 times with those bytes in order; tx_req 1 cycle, ≥2 cycles after the last byte; tx_cmd_type=1; bench raises busy 4 cycles, drops it -> r0_done 1 pulse, grant=00.
- r0 and r1 both valid in IDLE from reset -> r0 served first, then r1. Repeat with both valid again -> r1 wins the tie (round-robin alternation).
- pint_busy held high (RX) during WAIT_IDLE for 20 cycles -> no tx_req until busy falls; then KICK follows.
- Kick with busy never rising -> after START_TO=16 cycles, err_start_to=1 and r0_done pulses; err_clr -> cleared.
- 70-byte frame with MAX_BYTES=64 -> exactly 64 FIFO pushes, err_overflow=1, remaining 6 bytes drained, and the frame is still kicked.
- pint_rx_latch with 0x5C, then pint_rx_req -> rx_valid with rx_byte=0x5C one cycle later, then rx_end. Assert reset mid-LOAD -> all outputs 0 immediately.

Source files
------------

// File: rtl/pint_arb.sv
// Round-robin two-master frame arbiter feeding the PINT TX FIFO, with a registered RX passthrough.
// One byte per cycle while loading; the FIFO push strobe trails the requester handshake by one cycle.
module pint_arb #(
   parameter int MAX_BYTES = 64,
   parameter int START_TO  = 16,
   parameter int CW        = 8
) (
   input  logic       clk,
   input  logic       reset,

   input  logic       r0_valid,
   input  logic [7:0] r0_data,
   input  logic       r0_last,
   input  logic       r0_cmd,
   output logic       r0_ready,
   output logic       r0_done,

   input  logic       r1_valid,
   input  logic [7:0] r1_data,
   input  logic       r1_last,
   input  logic       r1_cmd,
   output logic       r1_ready,
   output logic       r1_done,

   input  logic       pint_busy,
   output logic [7:0] pint_tx_char,
   output logic       pint_tx_char_latch,
   output logic       pint_tx_req,
   output logic       pint_tx_cmd_type,

   input  logic       pint_rx_latch,
   input  logic       pint_rx_req,
   input  logic [7:0] pint_rx_data,
   output logic       rx_valid,
   output logic [7:0] rx_byte,
   output logic       rx_end,

   output logic [1:0] grant,
   output logic       err_start_to,
   output logic       err_overflow,
   input  logic       err_clr
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WAIT_IDLE,
      KICK,
      WAIT_START,
      WAIT_DONE
   } state_t;

   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BYTES);
   localparam logic [CW-1:0] TO_LAST = CW'(START_TO - 1);

   state_t        state;
   state_t        state_nxt;
   logic [1:0]    grant_nxt;
   logic [1:0]    drain_q;
   logic [1:0]    drain_nxt;
   logic [1:0]    req;
   logic          rr_last;
   logic          cmd_q;
   logic [CW-1:0] byte_cnt;
   logic [CW-1:0] byte_cnt_inc;
   logic [CW-1:0] timer;

   logic          sel_valid;
   logic          sel_last;
   logic          sel_cmd;
   logic [7:0]    sel_data;
   logic          load_hs;
   logic          hit_max;
   logic          done_set;
   logic          to_set;
   logic          ovf_set;

   // A truncated frame keeps its requester's ready high until its last byte is swallowed.
   assign r0_ready = ((state == LOAD) && grant[0]) || drain_q[0];
   assign r1_ready = ((state == LOAD) && grant[1]) || drain_q[1];

   assign pint_tx_req      = (state == KICK) && !pint_busy;
   assign pint_tx_cmd_type = ((state == KICK) || (state == WAIT_START) || (state == WAIT_DONE)) && cmd_q;

   always_comb begin
      sel_valid    = grant[1] ? r1_valid : r0_valid;
      sel_last     = grant[1] ? r1_last  : r0_last;
      sel_cmd      = grant[1] ? r1_cmd   : r0_cmd;
      sel_data     = grant[1] ? r1_data  : r0_data;
      load_hs      = (state == LOAD) && sel_valid;
      byte_cnt_inc = (byte_cnt == '1) ? byte_cnt : byte_cnt + 1'b1;
      hit_max      = (byte_cnt_inc >= MAX_CNT);
      req          = {r1_valid & ~drain_q[1], r0_valid & ~drain_q[0]};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      done_set  = 1'b0;
      to_set    = 1'b0;
      ovf_set   = 1'b0;
      case (state)
         IDLE: begin
            if (|req) begin
               state_nxt = LOAD;
               if (req == 2'b11) begin
                  grant_nxt = rr_last ? 2'b01 : 2'b10;
               end else begin
                  grant_nxt = req;
               end
            end
         end
         LOAD: begin
            if (load_hs && (sel_last || hit_max)) begin
               state_nxt = WAIT_IDLE;
               ovf_set   = !sel_last;
            end
         end
         WAIT_IDLE: begin
            if (!pint_busy) begin
               state_nxt = KICK;
            end
         end
         KICK: begin
            // Busy can rise between WAIT_IDLE and KICK; back off rather than kick into it.
            state_nxt = pint_busy ? WAIT_IDLE : WAIT_START;
         end
         WAIT_START: begin
            if (pint_busy) begin
               state_nxt = WAIT_DONE;
            end else if (timer >= TO_LAST) begin
               state_nxt = IDLE;
               grant_nxt = 2'b00;
               done_set  = 1'b1;
               to_set    = 1'b1;
            end
         end
         WAIT_DONE: begin
            if (!pint_busy) begin
               state_nxt = IDLE;
               grant_nxt = 2'b00;
               done_set  = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            grant_nxt = 2'b00;
         end
      endcase
   end

   always_comb begin
      drain_nxt = drain_q & ~{r1_valid & r1_last, r0_valid & r0_last};
      if (ovf_set) begin
         drain_nxt = drain_nxt | grant;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grant              <= 2'b00;
         rr_last            <= 1'b1;
         drain_q            <= 2'b00;
         byte_cnt           <= '0;
         timer              <= '0;
         cmd_q              <= 1'b0;
         pint_tx_char       <= 8'h00;
         pint_tx_char_latch <= 1'b0;
         r0_done            <= 1'b0;
         r1_done            <= 1'b0;
         err_start_to       <= 1'b0;
         err_overflow       <= 1'b0;
      end else begin
         grant              <= grant_nxt;
         drain_q            <= drain_nxt;
         pint_tx_char_latch <= load_hs;
         r0_done            <= done_set && grant[0];
         r1_done            <= done_set && grant[1];

         if ((state == IDLE) && (|req)) begin
            rr_last <= grant_nxt[1];
         end

         if (state == IDLE) begin
            byte_cnt <= '0;
         end else if (load_hs) begin
            byte_cnt <= byte_cnt_inc;
         end

         if (load_hs) begin
            pint_tx_char <= sel_data;
            if (byte_cnt == '0) begin
               cmd_q <= sel_cmd;
            end
         end

         if (state == KICK) begin
            timer <= '0;
         end else if ((state == WAIT_START) && (timer != '1)) begin
            timer <= timer + 1'b1;
         end

         // A new error event wins over a coincident clear.
         err_start_to <= (err_start_to & ~err_clr) | to_set;
         err_overflow <= (err_overflow & ~err_clr) | ovf_set;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_valid <= 1'b0;
         rx_end   <= 1'b0;
         rx_byte  <= 8'h00;
      end else begin
         rx_valid <= pint_rx_latch;
         rx_end   <= pint_rx_req;
         if (pint_rx_latch) begin
            rx_byte <= pint_rx_data;
         end
      end
   end

endmodule

// File: tb/tb_pint_arb.sv
// Scoreboard bench for pint_arb: frame drivers, a PINT busy responder and an output monitor.
`timescale 1ns/1ps
module tb_pint_arb;

   localparam int MAX_BYTES = 64;
   localparam int START_TO  = 16;
   localparam int CW        = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       r0_valid, r0_last, r0_cmd, r0_ready, r0_done;
   logic [7:0] r0_data;
   logic       r1_valid, r1_last, r1_cmd, r1_ready, r1_done;
   logic [7:0] r1_data;
   logic       pint_busy, auto_busy, hold_busy, auto_en;
   logic [7:0] pint_tx_char;
   logic       pint_tx_char_latch, pint_tx_req, pint_tx_cmd_type;
   logic       pint_rx_latch, pint_rx_req;
   logic [7:0] pint_rx_data;
   logic       rx_valid, rx_end;
   logic [7:0] rx_byte;
   logic [1:0] grant;
   logic       err_start_to, err_overflow, err_clr;

   assign pint_busy = auto_busy | hold_busy;

   pint_arb #(.MAX_BYTES(MAX_BYTES), .START_TO(START_TO), .CW(CW)) dut (
      .clk(clk), .reset(reset),
      .r0_valid(r0_valid), .r0_data(r0_data), .r0_last(r0_last), .r0_cmd(r0_cmd),
      .r0_ready(r0_ready), .r0_done(r0_done),
      .r1_valid(r1_valid), .r1_data(r1_data), .r1_last(r1_last), .r1_cmd(r1_cmd),
      .r1_ready(r1_ready), .r1_done(r1_done),
      .pint_busy(pint_busy), .pint_tx_char(pint_tx_char), .pint_tx_char_latch(pint_tx_char_latch),
      .pint_tx_req(pint_tx_req), .pint_tx_cmd_type(pint_tx_cmd_type),
      .pint_rx_latch(pint_rx_latch), .pint_rx_req(pint_rx_req), .pint_rx_data(pint_rx_data),
      .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_end(rx_end),
      .grant(grant), .err_start_to(err_start_to), .err_overflow(err_overflow), .err_clr(err_clr)
   );

   initial forever #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] n;
      logic        cmd;
      logic [7:0]  base;
   } frame_t;

   frame_t     fq0[$], fq1[$];
   frame_t     cur[2];
   int         idx[2];
   bit         act[2];
   int         acc_cnt[2];
   logic [7:0] exp_push[$];
   logic [1:0] exp_done[$];
   logic       exp_cmd[$];
   logic [1:0] grant_log[$];

   int n_chk = 0, n_pass = 0;
   int cyc = 0, push_cnt = 0, req_cnt = 0;
   int last_latch_cyc = -1, req_cyc = 0, done_cyc = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   function automatic frame_t mk(input int n, input logic cmd, input logic [7:0] base);
      frame_t f;
      f.n    = 16'(n);
      f.cmd  = cmd;
      f.base = base;
      return f;
   endfunction

   initial forever @(posedge clk) cyc++;

   // Frame drivers for both requesters; expectations are queued as each byte is handed over.
   initial begin : driver
      bit hs[2];
      cur[0] = mk(1, 1'b0, 8'h00);
      cur[1] = mk(1, 1'b0, 8'h00);
      r0_valid = 0; r0_data = 0; r0_last = 0; r0_cmd = 0;
      r1_valid = 0; r1_data = 0; r1_last = 0; r1_cmd = 0;
      forever begin
         @(negedge clk);
         hs[0] = act[0] && r0_valid && r0_ready && !reset;
         hs[1] = act[1] && r1_valid && r1_ready && !reset;
         for (int w = 0; w < 2; w++) begin
            if (hs[w]) begin
               if (idx[w] == 0) begin
                  exp_done.push_back((w == 0) ? 2'b01 : 2'b10);
                  exp_cmd.push_back(cur[w].cmd);
               end
               if (idx[w] < MAX_BYTES) exp_push.push_back(cur[w].base + 8'(idx[w]));
            end
         end
         @(posedge clk);
         #1;
         if (reset) begin
            act[0] = 0;
            act[1] = 0;
            exp_push.delete();
            exp_done.delete();
            exp_cmd.delete();
         end else begin
            for (int w = 0; w < 2; w++) begin
               if (hs[w]) begin
                  idx[w]++;
                  acc_cnt[w]++;
                  if (idx[w] == int'(cur[w].n)) act[w] = 0;
               end
            end
            if (!act[0] && fq0.size() > 0) begin cur[0] = fq0.pop_front(); idx[0] = 0; act[0] = 1; end
            if (!act[1] && fq1.size() > 0) begin cur[1] = fq1.pop_front(); idx[1] = 0; act[1] = 1; end
         end
         r0_valid = act[0]; r0_data = cur[0].base + 8'(idx[0]);
         r0_last  = (idx[0] == int'(cur[0].n) - 1); r0_cmd = cur[0].cmd;
         r1_valid = act[1]; r1_data = cur[1].base + 8'(idx[1]);
         r1_last  = (idx[1] == int'(cur[1].n) - 1); r1_cmd = cur[1].cmd;
      end
   end

   // PINT model: goes busy the cycle after a kick and stays busy for four cycles.
   initial begin : responder
      auto_busy = 0;
      forever begin
         @(posedge clk);
         #1;
         if (pint_tx_req && auto_en && !reset) begin
            @(posedge clk);
            #1 auto_busy = 1;
            repeat (4) @(posedge clk);
            #1 auto_busy = 0;
         end
      end
   end

   initial begin : monitor
      logic [1:0] pg;
      pg = 2'b00;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (pint_tx_char_latch) begin
               push_cnt++;
               last_latch_cyc = cyc;
               if (exp_push.size() == 0) chk("push_unexpected", pint_tx_char_latch, 0);
               else chk("push_byte", pint_tx_char, exp_push.pop_front());
            end
            if (pint_tx_req) begin
               req_cnt++;
               req_cyc = cyc;
               chk("req_while_busy", pint_busy, 0);
               chk("req_after_last_push", cyc > last_latch_cyc, 1);
               if (exp_cmd.size() == 0) chk("req_unexpected", pint_tx_req, 0);
               else chk("req_cmd", pint_tx_cmd_type, exp_cmd.pop_front());
            end
            if (r0_done || r1_done) begin
               done_cyc = cyc;
               if (exp_done.size() == 0) chk("done_unexpected", {r1_done, r0_done}, 0);
               else chk("done_who", {r1_done, r0_done}, exp_done.pop_front());
               chk("done_grant_clear", grant, 0);
            end
            if (grant != 2'b00 && pg == 2'b00) grant_log.push_back(grant);
            pg = grant;
         end else begin
            pg = 2'b00;
         end
      end
   end

   task automatic wait_idle(input string tag, input int budget);
      int n;
      n = 0;
      while ((act[0] || act[1] || fq0.size() != 0 || fq1.size() != 0 ||
              exp_done.size() != 0 || exp_push.size() != 0) && n < budget) begin
         @(posedge clk);
         n++;
      end
      chk({tag, "_timeout"}, n >= budget, 0);
      repeat (2) @(posedge clk);
      #2;
   endtask

   task automatic pulse_clr();
      @(posedge clk);
      #2 err_clr = 1;
      @(posedge clk);
      #2 err_clr = 0;
   endtask

   initial begin : main
      int pc0, rq0, a1;
      logic [1:0] arb_exp[3];
      arb_exp[0] = 2'b01; arb_exp[1] = 2'b10; arb_exp[2] = 2'b01;
      hold_busy = 0; auto_en = 1; err_clr = 0;
      pint_rx_latch = 0; pint_rx_req = 0; pint_rx_data = 0;
      reset = 1;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_grant", grant, 0);
      chk("rst_r0_ready", r0_ready, 0);
      chk("rst_r1_ready", r1_ready, 0);
      chk("rst_latch", pint_tx_char_latch, 0);
      chk("rst_char", pint_tx_char, 0);
      chk("rst_req", pint_tx_req, 0);
      chk("rst_cmd", pint_tx_cmd_type, 0);
      chk("rst_done", {r1_done, r0_done}, 0);
      chk("rst_rx", {rx_valid, rx_end, rx_byte}, 0);
      chk("rst_errs", {err_start_to, err_overflow}, 0);
      reset = 0;

      // Tie from reset goes to r0; the next tie alternates to r1.
      @(posedge clk);
      #2;
      grant_log.delete();
      fq0.push_back(mk(2, 1'b0, 8'h10));
      fq1.push_back(mk(2, 1'b1, 8'h20));
      fq0.push_back(mk(2, 1'b1, 8'h30));
      wait_idle("arb", 300);
      chk("arb_count", grant_log.size(), 3);
      for (int i = 0; i < 3; i++)
         chk($sformatf("arb_order%0d", i), (grant_log.size() > i) ? grant_log[i] : 2'b00, arb_exp[i]);

      pc0 = push_cnt; rq0 = req_cnt;
      fq0.push_back(mk(3, 1'b1, 8'hA1));
      wait_idle("basic", 200);
      chk("basic_pushes", push_cnt - pc0, 3);
      chk("basic_reqs", req_cnt - rq0, 1);
      chk("basic_done_lat", done_cyc - req_cyc, 6);

      hold_busy = 1;
      pc0 = push_cnt; rq0 = req_cnt;
      fq1.push_back(mk(4, 1'b0, 8'h50));
      repeat (30) @(posedge clk);
      #2;
      chk("hold_pushes", push_cnt - pc0, 4);
      chk("hold_no_req", req_cnt - rq0, 0);
      hold_busy = 0;
      wait_idle("hold", 200);
      chk("hold_req_after", req_cnt - rq0, 1);

      auto_en = 0;
      fq0.push_back(mk(1, 1'b0, 8'h66));
      wait_idle("start_to", 200);
      chk("start_to_err", err_start_to, 1);
      chk("start_to_lat", done_cyc - req_cyc, START_TO + 1);
      chk("start_to_no_ovf", err_overflow, 0);
      auto_en = 1;
      pulse_clr();
      chk("start_to_clr", err_start_to, 0);

      pc0 = push_cnt; rq0 = req_cnt; a1 = acc_cnt[1];
      fq1.push_back(mk(70, 1'b1, 8'h00));
      wait_idle("ovf", 600);
      chk("ovf_pushes", push_cnt - pc0, MAX_BYTES);
      chk("ovf_accepted", acc_cnt[1] - a1, 70);
      chk("ovf_err", err_overflow, 1);
      chk("ovf_kicked", req_cnt - rq0, 1);
      chk("ovf_drain_end", r1_ready, 0);
      pulse_clr();
      chk("ovf_clr", err_overflow, 0);

      pc0 = push_cnt;
      fq0.push_back(mk(MAX_BYTES, 1'b0, 8'h80));
      wait_idle("exact", 600);
      chk("exact_pushes", push_cnt - pc0, MAX_BYTES);
      chk("exact_no_ovf", err_overflow, 0);

      @(posedge clk);
      #2 pint_rx_latch = 1; pint_rx_data = 8'h5C;
      @(posedge clk);
      #2 pint_rx_latch = 0; pint_rx_req = 1; pint_rx_data = 8'h77;
      @(negedge clk);
      chk("rx_valid", rx_valid, 1);
      chk("rx_byte", rx_byte, 8'h5C);
      chk("rx_end_early", rx_end, 0);
      @(posedge clk);
      #2 pint_rx_req = 0;
      @(negedge clk);
      chk("rx_valid_pulse", rx_valid, 0);
      chk("rx_end", rx_end, 1);
      chk("rx_byte_hold", rx_byte, 8'h5C);
      @(posedge clk);
      #2 pint_rx_latch = 1; pint_rx_req = 1; pint_rx_data = 8'h3E;
      @(posedge clk);
      #2 pint_rx_latch = 0; pint_rx_req = 0;
      @(negedge clk);
      chk("rx_both", {rx_valid, rx_end, rx_byte}, {2'b11, 8'h3E});

      @(posedge clk);
      #2;
      fq0.push_back(mk(10, 1'b0, 8'hC0));
      repeat (4) @(posedge clk);
      #1;
      chk("prerst_latch", pint_tx_char_latch, 1);
      chk("prerst_grant", grant, 2'b01);
      #1 reset = 1;
      #1;
      chk("midrst_grant", grant, 0);
      chk("midrst_ready", r0_ready, 0);
      chk("midrst_latch", pint_tx_char_latch, 0);
      chk("midrst_char", pint_tx_char, 0);
      chk("midrst_done", r0_done, 0);
      repeat (3) @(posedge clk);
      #2 reset = 0;
      repeat (6) @(posedge clk);
      #2;
      chk("postrst_grant", grant, 0);
      chk("postrst_pushes_idle", pint_tx_char_latch, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: got no finish expected finish by %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
